// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data-memory read port and one write port between core 1 and
//   core 2. Each channel has its own round-robin pointer. A read tag pipeline
//   routes the returned data back to the core that issued the read, and
//   forwards write data when a read and a write to the same address issue in
//   the same cycle.
//
// Handshake: rreq_x/wreq_x are levels held by the core until the matching
//   rgnt_x/wgnt_x is seen high in the same cycle. A request and its grant
//   together form the transfer; the address/data are taken in that cycle.
//   rvalid_x is a one-cycle strobe with no back-pressure. stall_x tells the
//   core to hold its pipeline.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   rreq_x, raddr_x           read request / word address per core
//   rgnt_x                    read grant (combinational)
//   rvalid_x, rdata_x         read return strobe and data
//   wreq_x, waddr_x, wdata_x  write request / address / data per core
//   wgnt_x                    write grant (combinational)
//   stall_x                   core must hold its pipeline
//   mem_raddr                 {valid, address} to the mem read port
//   mem_rdata                 mem read data, READ_LAT after mem_raddr
//   mem_wen, mem_waddr, mem_wdata  mem write port
module dmem_arbiter #(
  parameter int READ_LAT = 2,
  parameter int AW       = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rreq_1,
  input  logic [AW-1:0] raddr_1,
  output logic          rgnt_1,
  output logic          rvalid_1,
  output logic [15:0]   rdata_1,
  input  logic          rreq_2,
  input  logic [AW-1:0] raddr_2,
  output logic          rgnt_2,
  output logic          rvalid_2,
  output logic [15:0]   rdata_2,
  input  logic          wreq_1,
  input  logic [AW-1:0] waddr_1,
  input  logic [15:0]   wdata_1,
  output logic          wgnt_1,
  input  logic          wreq_2,
  input  logic [AW-1:0] waddr_2,
  input  logic [15:0]   wdata_2,
  output logic          wgnt_2,
  output logic          stall_1,
  output logic          stall_2,
  output logic [AW:0]   mem_raddr,
  input  logic [15:0]   mem_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [15:0]   mem_wdata
);

  // Per-read tag: valid, owner (0 = core 1, 1 = core 2), forward flag and
  // the write data captured when forwarding applies.
  typedef struct packed {
    logic        v;
    logic        own;
    logic        fwd;
    logic [15:0] d;
  } tag_t;

  logic          rr_r;   // 0 favours core 1 on the read channel
  logic          rr_w;   // 0 favours core 1 on the write channel
  logic          out_1;  // core 1 has a read in flight
  logic          out_2;  // core 2 has a read in flight
  logic          elig_1;
  logic          elig_2;
  logic          rd_go;
  logic          wr_go;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          fwd;
  logic [15:0]   ret_data;
  tag_t          iss_tag;             // tag for the read on mem_raddr now
  tag_t          pipe [READ_LAT];     // tag in flight until data returns
  tag_t          ret;

  assign ret = pipe[READ_LAT-1];

  always_comb begin
    rvalid_1 = ret.v & ~ret.own;
    rvalid_2 = ret.v & ret.own;
    ret_data = ret.fwd ? ret.d : mem_rdata;
    // mem_rdata is meaningless unless a tracked read returns now.
    rdata_1  = ret.v ? ret_data : 16'h0000;
    rdata_2  = ret.v ? ret_data : 16'h0000;
  end

  // A core whose read returns this cycle may be granted again at once.
  assign elig_1 = rreq_1 & (~out_1 | rvalid_1);
  assign elig_2 = rreq_2 & (~out_2 | rvalid_2);

  // Grants are held off during reset so no request is lost to the clear.
  always_comb begin
    rgnt_1 = ~rst & elig_1 & (~elig_2 | ~rr_r);
    rgnt_2 = ~rst & elig_2 & (~elig_1 | rr_r);
    wgnt_1 = ~rst & wreq_1 & (~wreq_2 | ~rr_w);
    wgnt_2 = ~rst & wreq_2 & (~wreq_1 | rr_w);
  end

  always_comb begin
    rd_go   = rgnt_1 | rgnt_2;
    wr_go   = wgnt_1 | wgnt_2;
    rd_addr = rgnt_2 ? raddr_2 : raddr_1;
    wr_addr = wgnt_2 ? waddr_2 : waddr_1;
    wr_data = wgnt_2 ? wdata_2 : wdata_1;
    // Same-cycle read/write to one address: the read must see the new data,
    // which the mem block would otherwise not return.
    fwd     = rd_go & wr_go & (rd_addr == wr_addr);
  end

  always_comb begin
    stall_1 = (rreq_1 & ~rgnt_1) | (wreq_1 & ~wgnt_1) | (out_1 & ~rvalid_1);
    stall_2 = (rreq_2 & ~rgnt_2) | (wreq_2 & ~wgnt_2) | (out_2 & ~rvalid_2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r      <= 1'b0;
      rr_w      <= 1'b0;
      out_1     <= 1'b0;
      out_2     <= 1'b0;
      mem_raddr <= '0;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      iss_tag   <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      if (rgnt_1)      rr_r <= 1'b1;
      else if (rgnt_2) rr_r <= 1'b0;
      if (wgnt_1)      rr_w <= 1'b1;
      else if (wgnt_2) rr_w <= 1'b0;

      out_1 <= rgnt_1 | (out_1 & ~rvalid_1);
      out_2 <= rgnt_2 | (out_2 & ~rvalid_2);

      mem_raddr <= {rd_go, (rd_go ? rd_addr : {AW{1'b0}})};
      mem_wen   <= wr_go;
      mem_waddr <= wr_go ? wr_addr : {AW{1'b0}};
      mem_wdata <= wr_go ? wr_data : 16'h0000;

      iss_tag.v   <= rd_go;
      iss_tag.own <= rgnt_2;
      iss_tag.fwd <= fwd;
      iss_tag.d   <= fwd ? wr_data : 16'h0000;

      pipe[0] <= iss_tag;
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (READ_LAT = 2, AW = 15). A small memory
// model answers reads two cycles after mem_raddr is seen. Inputs change 1
// time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          rreq_1, rreq_2, wreq_1, wreq_2;
  logic [AW-1:0] raddr_1, raddr_2, waddr_1, waddr_2;
  logic [15:0]   wdata_1, wdata_2;
  logic          rgnt_1, rgnt_2, wgnt_1, wgnt_2;
  logic          rvalid_1, rvalid_2;
  logic [15:0]   rdata_1, rdata_2;
  logic          stall_1, stall_2;
  logic [AW:0]   mem_raddr;
  logic [15:0]   mem_rdata;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;

  int n_tot = 0;
  int n_bad = 0;

  dmem_arbiter #(.READ_LAT(2), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .rreq_1(rreq_1), .raddr_1(raddr_1), .rgnt_1(rgnt_1),
    .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .rreq_2(rreq_2), .raddr_2(raddr_2), .rgnt_2(rgnt_2),
    .rvalid_2(rvalid_2), .rdata_2(rdata_2),
    .wreq_1(wreq_1), .waddr_1(waddr_1), .wdata_1(wdata_1), .wgnt_1(wgnt_1),
    .wreq_2(wreq_2), .waddr_2(waddr_2), .wdata_2(wdata_2), .wgnt_2(wgnt_2),
    .stall_1(stall_1), .stall_2(stall_2),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // clock
  always #5 clk = ~clk;

  // memory model: 256 words, read data two cycles after the address
  logic        mem_load;
  logic [15:0] mem [256];
  logic [15:0] d1, d2;
  assign mem_rdata = d2;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'hBEEF;
      mem[8'h11] <= 16'h5511;
      mem[8'h40] <= 16'h1234;
    end else if (mem_wen) begin
      mem[mem_waddr[7:0]] <= mem_wdata;
    end
    d1 <= mem[mem_raddr[7:0]];
    d2 <= d1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    rreq_1 = 0; rreq_2 = 0; wreq_1 = 0; wreq_2 = 0;
    raddr_1 = '0; raddr_2 = '0; waddr_1 = '0; waddr_2 = '0;
    wdata_1 = '0; wdata_2 = '0;
  endtask

  // Move to the start of the next cycle.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1;
    next();
    next();
    rst = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, {rgnt_1, rgnt_2, wgnt_1, wgnt_2, rvalid_1, rvalid_2,
                        stall_1, stall_2, mem_wen}, 32'h0);
    chk({tag, "_raddr"}, 32'(mem_raddr), 32'h0);
    chk({tag, "_rdata"}, {rdata_1, rdata_2}, 32'h0);
    chk({tag, "_wr"}, {1'b0, mem_waddr, mem_wdata}, 32'h0);
  endtask

  logic [7:0] eg1, eg2, ev1, ev2;

  initial begin
    mem_load = 1;
    do_reset();
    mem_load = 0;

    // reset state
    @(negedge clk);
    chk_all_zero("reset");
    next();

    // single read by core 1
    do_reset();
    rreq_1 = 1; raddr_1 = 15'h0010;
    @(negedge clk);
    chk("t1_rgnt_c0", rgnt_1, 1);
    chk("t1_stall_c0", stall_1, 0);
    next();
    rreq_1 = 0;
    @(negedge clk);
    chk("t1_raddr_c1", 32'(mem_raddr), 32'h8010);
    chk("t1_stall_c1", stall_1, 1);
    chk("t1_rvalid_c1", rvalid_1, 0);
    next();
    @(negedge clk);
    chk("t1_stall_c2", stall_1, 1);
    chk("t1_rvld_c2", mem_raddr[AW], 0);
    next();
    @(negedge clk);
    chk("t1_rvalid_c3", {rvalid_1, rvalid_2}, 2'b10);
    chk("t1_rdata_c3", rdata_1, 16'hBEEF);
    chk("t1_rdata2_c3", rdata_2, 16'hBEEF);
    chk("t1_stall_c3", stall_1, 0);
    next();
    @(negedge clk);
    chk("t1_rvalid_c4", rvalid_1, 0);
    next();

    // both cores read continuously for 6 cycles
    do_reset();
    raddr_1 = 15'h0010; raddr_2 = 15'h0011;
    eg1 = 8'b0000_1001; eg2 = 8'b0001_0010;
    ev1 = 8'b0100_1000; ev2 = 8'b1001_0000;
    for (int c = 0; c < 8; c++) begin
      rreq_1 = (c < 6);
      rreq_2 = (c < 6);
      @(negedge clk);
      chk($sformatf("t2_rgnt_1_c%0d", c), rgnt_1, eg1[c]);
      chk($sformatf("t2_rgnt_2_c%0d", c), rgnt_2, eg2[c]);
      chk($sformatf("t2_rvalid_1_c%0d", c), rvalid_1, ev1[c]);
      chk($sformatf("t2_rvalid_2_c%0d", c), rvalid_2, ev2[c]);
      if (ev1[c]) chk($sformatf("t2_rdata_1_c%0d", c), rdata_1, 16'hBEEF);
      if (ev2[c]) chk($sformatf("t2_rdata_2_c%0d", c), rdata_2, 16'h5511);
      next();
    end

    // both cores write 0x0020 in the same cycle
    do_reset();
    wreq_1 = 1; waddr_1 = 15'h0020; wdata_1 = 16'h1111;
    wreq_2 = 1; waddr_2 = 15'h0020; wdata_2 = 16'h2222;
    @(negedge clk);
    chk("t3_wgnt_c0", {wgnt_1, wgnt_2}, 2'b10);
    chk("t3_stall2_c0", stall_2, 1);
    chk("t3_wen_c0", mem_wen, 0);
    next();
    wreq_1 = 0;
    @(negedge clk);
    chk("t3_wgnt_c1", {wgnt_1, wgnt_2}, 2'b01);
    chk("t3_wen_c1", mem_wen, 1);
    chk("t3_wr_c1", {1'b0, mem_waddr, mem_wdata}, {1'b0, 15'h0020, 16'h1111});
    next();
    wreq_2 = 0;
    @(negedge clk);
    chk("t3_wen_c2", mem_wen, 1);
    chk("t3_wr_c2", {1'b0, mem_waddr, mem_wdata}, {1'b0, 15'h0020, 16'h2222});
    next();
    @(negedge clk);
    chk("t3_wen_c3", mem_wen, 0);
    next();

    // same-cycle write by core 1 and read by core 2 of 0x0040
    do_reset();
    wreq_1 = 1; waddr_1 = 15'h0040; wdata_1 = 16'hCAFE;
    rreq_2 = 1; raddr_2 = 15'h0040;
    @(negedge clk);
    chk("t4_gnt_c0", {wgnt_1, rgnt_2}, 2'b11);
    next();
    clr_in();
    next();
    next();
    @(negedge clk);
    chk("t4_rvalid_c3", {rvalid_1, rvalid_2}, 2'b01);
    chk("t4_memrd_c3", mem_rdata, 16'h1234);
    chk("t4_rdata_c3", rdata_2, 16'hCAFE);
    next();

    // core 1 holds rreq_1 while its read is outstanding
    do_reset();
    rreq_1 = 1; raddr_1 = 15'h0010;
    @(negedge clk);
    chk("t5_rgnt_c0", rgnt_1, 1);
    next();
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t5_rgnt_c%0d", c), rgnt_1, 0);
      chk($sformatf("t5_stall_c%0d", c), stall_1, 1);
      next();
    end
    @(negedge clk);
    chk("t5_rvalid_c3", rvalid_1, 1);
    chk("t5_rgnt_c3", rgnt_1, 1);
    chk("t5_stall_c3", stall_1, 0);
    next();
    rreq_1 = 0;
    @(negedge clk);
    chk("t5_stall_c4", stall_1, 1);
    next();

    // reset one cycle after a read grant drops the read
    do_reset();
    rreq_1 = 1; raddr_1 = 15'h0010;
    @(negedge clk);
    chk("t6_rgnt_c0", rgnt_1, 1);
    next();
    rreq_1 = 0;
    rst = 1;
    next();
    rst = 0;
    @(negedge clk);
    chk_all_zero("t6_after_rst");
    for (int c = 3; c < 6; c++) begin
      next();
      @(negedge clk);
      chk($sformatf("t6_rvalid_c%0d", c), {rvalid_1, rvalid_2}, 2'b00);
    end
    next();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
